// File: rtl/sp_ram_pkg.sv
// Shared types and helpers for the banked single-port RAM wrapper.
package sp_ram_pkg;

    // Sequencer state: clear the array after reset, then serve requests.
    typedef enum logic {
        StInit,
        StReady
    } ram_state_e;

    // Byte-enable merge of one byte lane.
    function automatic logic [7:0] be_merge_byte(input logic [7:0] old_byte,
                                                 input logic [7:0] new_byte,
                                                 input logic       en);
        return en ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/ram_bank_array.sv
// One RAM bank: synchronous byte-enable write, registered write-first read.
module ram_bank_array
    import sp_ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BANK_WORDS = 2048,
    parameter int unsigned ROW_W      = 11
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    en_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [ROW_W-1:0]        addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    localparam int unsigned BE_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [BANK_WORDS];
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] rdata_q;

    // Post-write word: stored word with enabled byte lanes replaced.
    always_comb begin
        merged = mem_q[addr_i];
        for (int k = 0; k < BE_W; k++) begin
            merged[8*k +: 8] = be_merge_byte(mem_q[addr_i][8*k +: 8], wdata_i[8*k +: 8], be_i[k]);
        end
    end

    // Array write; storage is not reset, the wrapper clears it explicitly.
    always_ff @(posedge clk_i) begin
        if (en_i && we_i) begin
            mem_q[addr_i] <= merged;
        end
    end

    // Registered read port; write-first so a write returns the merged word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (en_i) begin
            rdata_q <= we_i ? merged : mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sp_ram_banked_wrap.sv
// Word-interleaved banked SRAM wrapper with req/gnt/rvalid handshake,
// write bypass and a post-reset zero-clear sequencer.
module sp_ram_banked_wrap
    import sp_ram_pkg::*;
#(
    parameter int unsigned RAM_SIZE   = 32768,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_BANKS  = 4,
    parameter int unsigned ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int unsigned INIT_ZERO  = 1
) (
    input  logic                    clk,
    input  logic                    rstn_i,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic                    bypass_en_i,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    init_done_o
);

    localparam int unsigned BE_W       = DATA_WIDTH / 8;
    localparam int unsigned OFF_W      = $clog2(BE_W);
    localparam int unsigned BANK_SEL_W = $clog2(NUM_BANKS);
    localparam int unsigned BANK_WORDS = RAM_SIZE / (BE_W * NUM_BANKS);
    localparam int unsigned WORD_W     = ADDR_WIDTH - OFF_W;
    localparam int unsigned ROW_W      = WORD_W - BANK_SEL_W;
    localparam int unsigned SEL_W      = (BANK_SEL_W > 0) ? BANK_SEL_W : 1;
    localparam logic [WORD_W-1:0] BANK_MASK = WORD_W'(NUM_BANKS - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(BANK_WORDS - 1);

    if ((NUM_BANKS == 0) || ((NUM_BANKS & (NUM_BANKS - 1)) != 0)) begin : g_err_banks
        $error("NUM_BANKS must be a power of two");
    end
    if ((DATA_WIDTH % 8) != 0) begin : g_err_width
        $error("DATA_WIDTH must be a multiple of 8");
    end
    if ((RAM_SIZE % (BE_W * NUM_BANKS)) != 0) begin : g_err_size
        $error("RAM_SIZE must be a multiple of BE_W*NUM_BANKS");
    end

    ram_state_e state_q, state_d;
    logic [ROW_W-1:0] cnt_q, cnt_d;
    logic             init_we;

    logic [WORD_W-1:0] word;
    logic [SEL_W-1:0]  bank_sel;
    logic [ROW_W-1:0]  row;
    logic              accept;
    logic              byp_wr;

    logic [NUM_BANKS-1:0]  bank_en;
    logic                  arr_we;
    logic [BE_W-1:0]       arr_be;
    logic [ROW_W-1:0]      arr_addr;
    logic [DATA_WIDTH-1:0] arr_wdata;
    logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];

    logic                  rvalid_q;
    logic [SEL_W-1:0]      sel_q;
    logic                  byp_q;
    logic [DATA_WIDTH-1:0] byp_data_q;

    // Sequencer state and clear-row counter.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= StInit;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sequencer next state: walk every row once, then serve forever.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        init_we = 1'b0;
        unique case (state_q)
            StInit: begin
                if (INIT_ZERO != 0) begin
                    init_we = 1'b1;
                    if (cnt_q == LAST_ROW) begin
                        state_d = StReady;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    state_d = StReady;
                end
            end
            StReady: state_d = StReady;
            default: state_d = StInit;
        endcase
    end

    assign gnt_o       = (state_q == StReady);
    assign init_done_o = (state_q == StReady);

    // Address split and per-bank enables; the clear drives all banks at once.
    always_comb begin
        word      = WORD_W'(addr_i >> OFF_W);
        bank_sel  = SEL_W'(word & BANK_MASK);
        row       = ROW_W'(word >> BANK_SEL_W);
        accept    = req_i & gnt_o;
        byp_wr    = we_i & bypass_en_i;
        arr_we    = init_we | we_i;
        arr_be    = init_we ? '1 : be_i;
        arr_addr  = init_we ? cnt_q : row;
        arr_wdata = init_we ? '0 : wdata_i;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_en[b] = init_we | (accept & ~byp_wr & (bank_sel == SEL_W'(b)));
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        ram_bank_array #(
            .DATA_WIDTH (DATA_WIDTH),
            .BANK_WORDS (BANK_WORDS),
            .ROW_W      (ROW_W)
        ) u_bank (
            .clk_i   (clk),
            .rst_ni  (rstn_i),
            .en_i    (bank_en[b]),
            .we_i    (arr_we),
            .be_i    (arr_be),
            .addr_i  (arr_addr),
            .wdata_i (arr_wdata),
            .rdata_o (bank_rdata[b])
        );
    end

    // Response bookkeeping; selects only move on accepted requests so rdata_o holds.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            rvalid_q   <= 1'b0;
            sel_q      <= '0;
            byp_q      <= 1'b0;
            byp_data_q <= '0;
        end else begin
            rvalid_q <= accept;
            if (accept) begin
                sel_q <= bank_sel;
                byp_q <= byp_wr;
                if (byp_wr) begin
                    byp_data_q <= wdata_i;
                end
            end
        end
    end

    // Output mux over the bank read registers and the bypass register.
    always_comb begin
        rdata_o = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (sel_q == SEL_W'(b)) begin
                rdata_o = bank_rdata[b];
            end
        end
        if (byp_q) begin
            rdata_o = byp_data_q;
        end
    end

    assign rvalid_o = rvalid_q;

endmodule

// File: tb/tb_sp_ram_banked_wrap.sv
// Bench for sp_ram_banked_wrap: default config plus a no-clear, single-bank config.
module tb_sp_ram_banked_wrap;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req = 1'b0, we = 1'b0, byp = 1'b0;
    logic [3:0]  be = '0;
    logic [14:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        gnt, rvalid, done;
    logic [31:0] rdata;

    logic        rstn1 = 1'b0;
    logic        req1 = 1'b0, we1 = 1'b0;
    logic [3:0]  be1 = '0;
    logic [11:0] addr1 = '0;
    logic [31:0] wdata1 = '0;
    logic        gnt1, rvalid1, done1;
    logic [31:0] rdata1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q [$];
    logic [31:0] model [int];

    always #5 clk = ~clk;

    sp_ram_banked_wrap u_dut (
        .clk         (clk),
        .rstn_i      (rstn),
        .req_i       (req),
        .gnt_o       (gnt),
        .addr_i      (addr),
        .we_i        (we),
        .be_i        (be),
        .wdata_i     (wdata),
        .bypass_en_i (byp),
        .rvalid_o    (rvalid),
        .rdata_o     (rdata),
        .init_done_o (done)
    );

    sp_ram_banked_wrap #(
        .RAM_SIZE  (4096),
        .NUM_BANKS (1),
        .INIT_ZERO (0)
    ) u_dut1 (
        .clk         (clk),
        .rstn_i      (rstn1),
        .req_i       (req1),
        .gnt_o       (gnt1),
        .addr_i      (addr1),
        .we_i        (we1),
        .be_i        (be1),
        .wdata_i     (wdata1),
        .bypass_en_i (1'b0),
        .rvalid_o    (rvalid1),
        .rdata_o     (rdata1),
        .init_done_o (done1)
    );

    // Scoreboard: one response per queued expectation, in order, no extras.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0 || rvalid) begin
            n_checks++;
            if (!rvalid) begin
                n_fail++;
                $display("FAIL sb_rvalid: rvalid=0 required 1 (expected data %h)", exp_q[0]);
                void'(exp_q.pop_front());
            end else if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_spurious: rvalid=1 with no request outstanding, rdata=%h", rdata);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (rdata !== e) begin
                    n_fail++;
                    $display("FAIL sb_rdata: rdata=%h required %h", rdata, e);
                end
            end
        end
    end

    // Drive one request for a cycle (called at a negedge) and queue its expected response.
    task automatic drive(input logic w, input logic [3:0] b, input logic [14:0] a,
                         input logic [31:0] d, input logic bp);
        int          wi;
        logic [31:0] old, nw;
        req = 1'b1; we = w; be = b; addr = a; wdata = d; byp = bp;
        wi  = int'(a >> 2);
        old = model.exists(wi) ? model[wi] : 32'h0;
        if (w && bp) begin
            exp_q.push_back(d);
        end else if (w) begin
            nw = old;
            for (int k = 0; k < 4; k++) if (b[k]) nw[8*k +: 8] = d[8*k +: 8];
            model[wi] = nw;
            exp_q.push_back(nw);
        end else begin
            exp_q.push_back(old);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req = 1'b0; we = 1'b0; byp = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        logic bad = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (gnt !== 1'b0 || rvalid !== 1'b0 || done !== 1'b0 || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_values: gnt=%b rvalid=%b done=%b rdata=%h required 0 0 0 0",
                     gnt, rvalid, done, rdata);
        end
        rstn = 1'b1;
        // Reads during INIT must be dropped; the scoreboard flags any rvalid.
        req = 1'b1; we = 1'b0; addr = 15'h0100;
        for (int n = 1; n < 2048; n++) begin
            @(negedge clk);
            if (gnt !== 1'b0 || done !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL init_gnt_low: gnt/done went high before cycle 2048, required low");
        end
        @(negedge clk);
        req = 1'b0;
        n_checks++;
        if (gnt !== 1'b1 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL init_done_2048: gnt=%b done=%b required 1 1", gnt, done);
        end
        drive(1'b0, 4'h0, 15'h0100, 32'h0, 1'b0);
        idle(2);
    endtask

    task automatic test_byte_enable();
        drive(1'b1, 4'hF, 15'h0004, 32'hDEADBEEF, 1'b0);
        drive(1'b1, 4'h2, 15'h0004, 32'h0000AA00, 1'b0);
        drive(1'b0, 4'h0, 15'h0004, 32'h0, 1'b0);
        drive(1'b1, 4'h0, 15'h0004, 32'hFFFFFFFF, 1'b0);
        drive(1'b0, 4'h0, 15'h0004, 32'h0, 1'b0);
        idle(2);
    endtask

    task automatic test_interleave();
        logic [14:0] a [5] = '{15'h0000, 15'h0004, 15'h0008, 15'h000C, 15'h7FFC};
        logic [31:0] d [5] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                               32'h55555555};
        for (int i = 0; i < 5; i++) drive(1'b1, 4'hF, a[i], d[i], 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b0, 4'h0, a[i], 32'h0, 1'b0);
        for (int i = 4; i >= 0; i--) drive(1'b0, 4'h0, a[i], 32'h0, 1'b0);
        idle(2);
    endtask

    task automatic test_bypass();
        drive(1'b1, 4'hF, 15'h0010, 32'hCAFEF00D, 1'b0);
        drive(1'b1, 4'hF, 15'h0010, 32'h12345678, 1'b1);
        drive(1'b0, 4'h0, 15'h0010, 32'h0, 1'b0);
        drive(1'b0, 4'h0, 15'h0010, 32'h0, 1'b1);
        drive(1'b1, 4'h0, 15'h0014, 32'h9ABCDEF0, 1'b1);
        drive(1'b0, 4'h0, 15'h0014, 32'h0, 1'b0);
        idle(2);
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 4'hF, 15'h0024, 32'h5A5A1234, 1'b0);
        drive(1'b0, 4'h0, 15'h0024, 32'h0, 1'b0);
        drive(1'b1, 4'h9, 15'h0024, 32'hA1B2C3D4, 1'b0);
        drive(1'b0, 4'h0, 15'h0024, 32'h0, 1'b0);
        idle(4);
        n_checks++;
        if (rvalid !== 1'b0 || rdata !== 32'hA15A12D4) begin
            n_fail++;
            $display("FAIL rdata_hold: rvalid=%b rdata=%h required 0 a15a12d4", rvalid, rdata);
        end
    endtask

    task automatic test_reset_mid_init();
        int n;
        rstn = 1'b0;
        #1;
        n_checks++;
        if (done !== 1'b0 || gnt !== 1'b0 || rvalid !== 1'b0 || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: done=%b gnt=%b rvalid=%b rdata=%h required 0 0 0 0",
                     done, gnt, rvalid, rdata);
        end
        @(negedge clk);
        rstn = 1'b1;
        model.delete();
        // Writes during INIT must be dropped and the clear must still cover them.
        req = 1'b1; we = 1'b1; be = 4'hF; addr = 15'h0004; wdata = 32'hFFFFFFFF;
        repeat (1000) @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_init_done: done=%b required 0 at INIT cycle 1000", done);
        end
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        n = 0;
        while (n < 3000) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) break;
        end
        req = 1'b0; we = 1'b0;
        n_checks++;
        if (n != 2048) begin
            n_fail++;
            $display("FAIL reinit_len: done rose after %0d cycles required 2048", n);
        end
        drive(1'b0, 4'h0, 15'h0004, 32'h0, 1'b0);
        drive(1'b0, 4'h0, 15'h7FFC, 32'h0, 1'b0);
        drive(1'b0, 4'h0, 15'h0024, 32'h0, 1'b0);
        idle(2);
    endtask

    task automatic test_no_init();
        rstn1 = 1'b1;
        #1;
        n_checks++;
        if (gnt1 !== 1'b0 || done1 !== 1'b0) begin
            n_fail++;
            $display("FAIL noinit_release: gnt=%b done=%b required 0 0", gnt1, done1);
        end
        @(negedge clk);
        n_checks++;
        if (gnt1 !== 1'b1 || done1 !== 1'b1) begin
            n_fail++;
            $display("FAIL noinit_gnt: gnt=%b done=%b required 1 1", gnt1, done1);
        end
        req1 = 1'b1; we1 = 1'b1; be1 = 4'hF; addr1 = 12'h100; wdata1 = 32'hA5A55A5A;
        @(negedge clk);
        n_checks++;
        if (rvalid1 !== 1'b1 || rdata1 !== 32'hA5A55A5A) begin
            n_fail++;
            $display("FAIL noinit_write: rvalid=%b rdata=%h required 1 a5a55a5a", rvalid1, rdata1);
        end
        we1 = 1'b1; be1 = 4'h4; wdata1 = 32'h00C30000;
        @(negedge clk);
        we1 = 1'b0;
        n_checks++;
        if (rvalid1 !== 1'b1 || rdata1 !== 32'hA5C35A5A) begin
            n_fail++;
            $display("FAIL noinit_merge: rvalid=%b rdata=%h required 1 a5c35a5a", rvalid1, rdata1);
        end
        @(negedge clk);
        req1 = 1'b0;
        n_checks++;
        if (rvalid1 !== 1'b1 || rdata1 !== 32'hA5C35A5A) begin
            n_fail++;
            $display("FAIL noinit_raw: rvalid=%b rdata=%h required 1 a5c35a5a", rvalid1, rdata1);
        end
        @(negedge clk);
        n_checks++;
        if (rvalid1 !== 1'b0) begin
            n_fail++;
            $display("FAIL noinit_idle: rvalid=%b required 0", rvalid1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, required finish before 500us");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_byte_enable();
        test_interleave();
        test_bypass();
        test_back_to_back();
        test_reset_mid_init();
        test_no_init();
        idle(2);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d responses outstanding required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sp_ram_banked_wrap.md
Name: sp_ram_banked_wrap

Overview:
Parametrised single-port, byte-addressed SRAM wrapper built from NUM_BANKS word-interleaved banks. Adds a req/gnt/rvalid handshake, a registered read port, a registered bypass path and a post-reset zero-initialisation sequencer. Drops in where the current single-bank RAM wrapper sits: instruction/data RAM behind the core's LSU/fetch interface.

Parameters:
RAM_SIZE, 32768, total capacity in bytes
DATA_WIDTH, 32, word width in bits; multiple of 8
NUM_BANKS, 4, interleaved banks; power of two, >=1
ADDR_WIDTH, $clog2(RAM_SIZE), byte-address width
INIT_ZERO, 1, 1 = clear all words after reset before granting
localparams: BE_W=DATA_WIDTH/8, OFF_W=$clog2(BE_W), BANK_SEL_W=$clog2(NUM_BANKS), BANK_WORDS=RAM_SIZE/(BE_W*NUM_BANKS)

Ports:
clk  in  1  clock
rstn_i  in  1  reset, asynchronous, active-low
req_i  in  1  request valid
gnt_o  out  1  request accepted this cycle (combinational on state, not on req_i)
addr_i  in  ADDR_WIDTH  byte address; low OFF_W bits ignored
we_i  in  1  1 = write
be_i  in  BE_W  byte enables for writes
wdata_i  in  DATA_WIDTH  write data
bypass_en_i  in  1  write bypass: suppress array write, echo wdata_i
rvalid_o  out  1  response valid, one per granted request
rdata_o  out  DATA_WIDTH  response data
init_done_o  out  1  high once array usable

Behaviour:
- Clock clk; reset rstn_i asynchronous, active-low. Reset values: gnt_o=0, rvalid_o=0, rdata_o=0, init_done_o=0, FSM=INIT, init row counter=0.
- Address split: word = addr_i[ADDR_WIDTH-1:OFF_W]; bank = word[BANK_SEL_W-1:0]; row = word[ADDR_WIDTH-OFF_W-1:BANK_SEL_W].
- FSM INIT: gnt_o=0; each cycle all banks write zero at row counter, all bytes. Counter BANK_WORDS-1 -> READY. INIT takes exactly BANK_WORDS cycles. With INIT_ZERO=0, INIT lasts one cycle with no writes.
- FSM READY: gnt_o=1, init_done_o=1. No exit except reset.
- Reset asserted mid-INIT aborts the sequence; the counter restarts at 0 on release. Partial contents are irrelevant because the full clear reruns.
- Requests while gnt_o=0 are dropped, not queued. No rvalid is produced for them.
- Accepted = req_i & gnt_o in cycle N. rvalid_o=1 in cycle N+1 for every accepted request; otherwise 0. Fixed latency 1; no back-pressure; a new request may be accepted every cycle.
- Read (we_i=0): rdata_o at N+1 = word at addr_i.
- Write (we_i=1, bypass_en_i=0): only bytes with be_i[k]=1 are updated at the N clock edge. rdata_o at N+1 = merged post-write word. be_i=0 writes nothing and still responds with the unchanged word.
- Write with bypass_en_i=1: array untouched; rdata_o at N+1 = wdata_i (full word, be_i ignored).
- Read with bypass_en_i=1: normal read; bypass_en_i is ignored.
- Read-after-write to the same address in consecutive cycles returns the new data; no hazard because the array is write-first.
- Only the addressed bank is enabled per access, to save power.
- rdata_o holds its last value while rvalid_o=0.
- Elaboration $error if NUM_BANKS is not a power of two, DATA_WIDTH%8!=0, or RAM_SIZE%(BE_W*NUM_BANKS)!=0.

Decomposition:
- Package sp_ram_pkg: state enum {INIT, READY}; helper function for byte-enable merge.
- Sub-module ram_bank_array: one bank, BANK_WORDS x DATA_WIDTH, synchronous byte-enable write, synchronous write-first read, en/we/be/addr/wdata/rdata. Generated NUM_BANKS times.
- Top holds the FSM, counter, bank decode, registered bank-select for output mux, rvalid and bypass registers.

Test Plan:
- Defaults, reset release: gnt_o=0 for 2048 cycles, init_done_o=1 at cycle 2048; read 0x0100 -> rvalid next cycle, rdata 0x00000000.
- Write 0xDEADBEEF be=4'b1111 @0x0004, then 0x0000AA00 be=4'b0010 @0x0004, read @0x0004 -> 0xDEADAAEF; write responses 0xDEADBEEF then 0xDEADAAEF.
- Interleave: back-to-back writes 0x11111111..0x44444444 to 0x0,0x4,0x8,0xC (banks 0-3) and 0x7FFC; reads every cycle -> same values with rvalid continuous, no bubbles.
- Bypass: after storing 0xCAFEF00D @0x0010, bypass write 0x12345678 -> response 0x12345678; next read @0x0010 -> 0xCAFEF00D.
- Reset pulse at INIT cycle 1000 after writing nothing: init_done_o drops to 0 and rises 2048 cycles after release; requests during INIT -> no rvalid.
- INIT_ZERO=0, NUM_BANKS=1, RAM_SIZE=4096: gnt_o=1 one cycle after release; read-after-write same address -> new data.
